// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants, FSM states and control-word layout for the debug frame serializer
package debug_pkg;

    localparam logic [7:0] DBG_HDR = 8'hA5;

    // Byte offsets of each field inside the frame
    localparam logic [7:0] OFS_PC  = 8'd1;
    localparam logic [7:0] OFS_INS = 8'd5;
    localparam logic [7:0] OFS_CTL = 8'd9;
    localparam logic [7:0] OFS_REG = 8'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } dbg_state_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic       branch_id;
        logic       mem_read_id;
        logic       mem_write_id;
        logic       alu_src_id;
        logic       reg_write_id;
        logic [1:0] reg_dst_id;
        logic [1:0] mem_to_reg_id;
        logic [1:0] alu_op_id;
        logic       mem_read_ex;
        logic       mem_write_ex;
        logic       reg_write_ex;
        logic [1:0] mem_to_reg_ex;
        logic       reg_write_mem;
        logic [1:0] mem_to_reg_mem;
    } dbg_ctrl_t;

    // Byte k of a 32-bit word, k = 0 selects the most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dbg_byte_mux.sv
// rtl/dbg_byte_mux.sv - combinational frame byte select for the current byte index
module dbg_byte_mux
    import debug_pkg::*;
#(
    parameter logic [7:0] HDR      = DBG_HDR,
    parameter logic [7:0] LAST_IDX = 8'd140
) (
    input  logic [7:0]  idx,
    input  logic [31:0] pc,
    input  logic [31:0] ins,
    input  logic [23:0] ctl,
    input  logic [31:0] reg_data,
    input  logic [7:0]  csum,
    output logic [7:0]  byte_sel
);

    logic [1:0] k_pc;
    logic [1:0] k_ins;
    logic [1:0] k_ctl;
    logic [1:0] k_reg;

    always_comb begin
        k_pc     = 2'(idx - OFS_PC);
        k_ins    = 2'(idx - OFS_INS);
        // ctl_word is 24 bits, so its first byte is byte 1 of the zero-extended word
        k_ctl    = 2'(idx - OFS_CTL + 8'd1);
        k_reg    = 2'(idx - OFS_REG);
        byte_sel = 8'h00;
        if (idx == LAST_IDX) begin
            byte_sel = csum;
        end else if (idx >= OFS_REG) begin
            byte_sel = word_byte(reg_data, k_reg);
        end else if (idx >= OFS_CTL) begin
            byte_sel = word_byte({8'h00, ctl}, k_ctl);
        end else if (idx >= OFS_INS) begin
            byte_sel = word_byte(ins, k_ins);
        end else if (idx >= OFS_PC) begin
            byte_sel = word_byte(pc, k_pc);
        end else begin
            byte_sel = HDR;
        end
    end

endmodule

// File: rtl/debug_frame_serializer.sv
// rtl/debug_frame_serializer.sv - snapshots pipeline debug state and streams it as a checksummed UART frame
module debug_frame_serializer
    import debug_pkg::*;
#(
    parameter logic [7:0] HDR  = DBG_HDR,
    parameter int         NREG = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture,
    input  logic [31:0] post_pc,
    input  logic [31:0] instruction,
    input  logic [23:0] ctrl_word,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done_tick,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int         FLEN     = 13 + 4 * NREG;
    localparam logic [7:0] LAST_IDX = 8'(FLEN - 1);

    dbg_state_e  state;
    logic [7:0]  idx;
    logic [7:0]  csum;
    logic [31:0] pc_q;
    logic [31:0] ins_q;
    dbg_ctrl_t   ctl_q;
    logic [7:0]  mux_byte;
    logic [7:0]  reg_rel;

    assign busy    = (state != ST_IDLE);
    assign reg_rel = idx - OFS_REG;
    assign reg_addr = (idx >= OFS_REG && idx < LAST_IDX) ? 5'(reg_rel >> 2) : 5'd0;

    dbg_byte_mux #(
        .HDR      (HDR),
        .LAST_IDX (LAST_IDX)
    ) u_byte_mux (
        .idx      (idx),
        .pc       (pc_q),
        .ins      (ins_q),
        .ctl      (ctl_q),
        .reg_data (reg_data),
        .csum     (csum),
        .byte_sel (mux_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            csum       <= '0;
            pc_q       <= '0;
            ins_q      <= '0;
            ctl_q      <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            if (capture && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        pc_q    <= post_pc;
                        ins_q   <= instruction;
                        ctl_q   <= dbg_ctrl_t'(ctrl_word);
                        idx     <= '0;
                        csum    <= '0;
                        overrun <= 1'b0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    tx_data  <= mux_byte;
                    // Header and the checksum byte itself stay out of the XOR
                    if (idx != 8'd0 && idx != LAST_IDX) begin
                        csum <= csum ^ mux_byte;
                    end
                    tx_start <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_tick) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// tb/tb_debug_frame_serializer.sv - directed self-checking bench for debug_frame_serializer
module tb_debug_frame_serializer;

    localparam int FLEN = 141;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        capture;
    logic [31:0] post_pc;
    logic [31:0] instruction;
    logic [23:0] ctrl_word;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done_tick;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    logic [31:0] regs  [0:31];
    logic [7:0]  got   [0:FLEN-1];
    logic [7:0]  exp_b [0:FLEN-1];
    int          n_vec = 0;
    int          n_err = 0;
    int          nbytes;

    always #5 clk = ~clk;

    assign reg_data = regs[reg_addr];

    debug_frame_serializer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .capture      (capture),
        .post_pc      (post_pc),
        .instruction  (instruction),
        .ctrl_word    (ctrl_word),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic build_exp(input logic [31:0] pc, input logic [31:0] ins, input logic [23:0] ctl);
        logic [7:0] cs;
        exp_b[0] = 8'hA5;
        for (int b = 0; b < 4; b++) begin
            exp_b[1 + b] = 8'(pc >> (24 - 8 * b));
            exp_b[5 + b] = 8'(ins >> (24 - 8 * b));
        end
        exp_b[9]  = ctl[23:16];
        exp_b[10] = ctl[15:8];
        exp_b[11] = ctl[7:0];
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                exp_b[12 + 4 * r + b] = 8'(regs[r] >> (24 - 8 * b));
            end
        end
        cs = 8'h00;
        for (int i = 1; i < FLEN - 1; i++) begin
            cs = cs ^ exp_b[i];
        end
        exp_b[FLEN-1] = cs;
    endtask

    // Serves one frame as the UART TX: done tick 5 cycles after every tx_start.
    // Caller drives capture=1 just after a negedge (cycle 0) before calling.
    task automatic run_frame(input int cap2_at, input int abort_at, input bit spur, input bit cap_at_done);
        int cyc;
        int last_evt;
        int due;
        int seen;
        bit aborted;
        cyc      = 0;
        last_evt = 0;
        due      = -1;
        seen     = 0;
        aborted  = 1'b0;
        nbytes   = 0;
        for (int i = 0; i < FLEN; i++) got[i] = 8'hxx;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            cyc++;
            capture      = 1'b0;
            tx_done_tick = 1'b0;
            if (cyc == 1) begin
                check("busy_after_capture", 32'(busy), 1);
                check("overrun_cleared", 32'(overrun), 0);
            end
            if (tx_start) begin
                check($sformatf("start_gap_b%0d", nbytes), cyc - last_evt, 2);
                if (nbytes < FLEN) got[nbytes] = tx_data;
                nbytes++;
                due = cyc + 5;
                if (nbytes == cap2_at) capture = 1'b1;
                if (nbytes == abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    check("abort_busy", 32'(busy), 0);
                    check("abort_tx_start", 32'(tx_start), 0);
                    aborted = 1'b1;
                    break;
                end
            end
            if (spur && cyc == last_evt + 1) tx_done_tick = 1'b1;
            if (cyc == due) begin
                check("tx_data_hold", 32'(tx_data), 32'(got[nbytes-1]));
                tx_done_tick = 1'b1;
                last_evt     = cyc;
            end
            if (frame_done) begin
                seen = 1;
                check("done_gap", cyc - last_evt, 1);
                if (cap_at_done) capture = 1'b1;
                break;
            end
        end
        if (!aborted) check("frame_done_seen", seen, 1);
    endtask

    task automatic post_frame(input bit exp_ovr);
        @(negedge clk);
        capture = 1'b0;
        check("frame_done_single", 32'(frame_done), 0);
        check("idle_after_frame", 32'(busy), 0);
        check("overrun_after_frame", 32'(overrun), 32'(exp_ovr));
        @(negedge clk);
        check("no_restart", 32'(busy), 0);
        check("no_restart_start", 32'(tx_start), 0);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_len"}, nbytes, FLEN);
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        capture      = 1'b0;
        tx_done_tick = 1'b0;
        post_pc      = '0;
        instruction  = '0;
        ctrl_word    = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_tx_start", 32'(tx_start), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_reg_addr", 32'(reg_addr), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Frame 1: basic frame
        post_pc     = 32'h0000_0010;
        instruction = 32'h8C22_0004;
        ctrl_word   = 24'h04A5F0;
        build_exp(post_pc, instruction, ctrl_word);
        capture = 1'b1;
        run_frame(0, 0, 1'b0, 1'b0);
        post_frame(1'b0);
        compare_frame("f1");
        check("f1_cksum", 32'(got[FLEN-1]), 32'h0000_00EB);

        // Frame 2: spurious ticks in IDLE and FETCH, second capture at byte 50
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        check("spur_idle_busy", 32'(busy), 0);
        check("spur_idle_start", 32'(tx_start), 0);
        capture = 1'b1;
        run_frame(50, 0, 1'b1, 1'b0);
        post_frame(1'b1);
        compare_frame("f2");

        // Frame 3: reset mid-frame at byte 20
        capture = 1'b1;
        run_frame(0, 20, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_busy", 32'(busy), 0);
            check("abort_hold_start", 32'(tx_start), 0);
            check("abort_hold_done", 32'(frame_done), 0);
            check("abort_hold_overrun", 32'(overrun), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Frame 4: all registers ones, capture coincident with DONE
        for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
        post_pc     = '0;
        instruction = '0;
        ctrl_word   = '0;
        build_exp(post_pc, instruction, ctrl_word);
        capture = 1'b1;
        run_frame(0, 0, 1'b0, 1'b1);
        post_frame(1'b1);
        compare_frame("f4");
        check("f4_cksum", 32'(got[FLEN-1]), 32'h0000_0000);

        // Frame 5: only r31 low byte set; accepted capture clears overrun
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[31] = 32'h0000_00FF;
        build_exp(post_pc, instruction, ctrl_word);
        capture = 1'b1;
        run_frame(0, 0, 1'b0, 1'b0);
        post_frame(1'b0);
        compare_frame("f5");
        check("f5_cksum", 32'(got[FLEN-1]), 32'h0000_00FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
